// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 red/green LED frame store with a frame-synchronous swap.
// Define LED_FB_CLEAR_EN to build in the back-buffer clear engine.
module led_frame_buffer #(
  parameter logic [2:0] FRAME_SYNC_ROW = 3'd7
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [7:0]      wr_red,
  input  logic [7:0]      wr_green,
  input  logic            swap_req,
  input  logic            clear_req,
  input  logic [2:0]      scan_row,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array,
  output logic            swap_pending,
  output logic            swap_done,
  output logic            clear_busy
);

`ifdef LED_FB_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1
  } state_t;
`endif

  logic [7:0][7:0] red_a;
  logic [7:0][7:0] grn_a;
  logic [7:0][7:0] red_b;
  logic [7:0][7:0] grn_b;
  logic            sel;

  state_t state;
  state_t state_nx;
  logic   done_q;
  logic   do_swap;
  logic   wr_ok;

`ifdef LED_FB_CLEAR_EN
  logic       swap_lat;
  logic       swap_lat_nx;
  logic [2:0] clr_cnt;
  logic [2:0] clr_cnt_nx;
  logic       clr_en;
`else
  logic       unused_clear;
  assign unused_clear = clear_req;
`endif

  // FSM state, swap latch, clear row counter and swap_done pulse
  always_ff @(posedge Clock) begin
    if (reset) begin
      state    <= S_IDLE;
      done_q   <= 1'b0;
`ifdef LED_FB_CLEAR_EN
      swap_lat <= 1'b0;
      clr_cnt  <= 3'd0;
`endif
    end else begin
      state    <= state_nx;
      done_q   <= do_swap;
`ifdef LED_FB_CLEAR_EN
      swap_lat <= swap_lat_nx;
      clr_cnt  <= clr_cnt_nx;
`endif
    end
  end

  // Next-state: clear wins over swap, swap only at the sync row
  always_comb begin
    state_nx    = state;
`ifdef LED_FB_CLEAR_EN
    swap_lat_nx = swap_lat;
    clr_cnt_nx  = clr_cnt;
`endif
    unique case (state)
      S_IDLE: begin
`ifdef LED_FB_CLEAR_EN
        if (clear_req) begin
          state_nx    = S_CLEAR;
          clr_cnt_nx  = 3'd0;
          swap_lat_nx = swap_req;
        end else
`endif
        if (swap_req) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (scan_row == FRAME_SYNC_ROW) begin
          state_nx = S_IDLE;
        end
      end
`ifdef LED_FB_CLEAR_EN
      S_CLEAR: begin
        clr_cnt_nx  = clr_cnt + 3'd1;
        swap_lat_nx = swap_lat | swap_req;
        if (clr_cnt == 3'd7) begin
          state_nx    = (swap_lat | swap_req) ? S_WAIT : S_IDLE;
          swap_lat_nx = 1'b0;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs and datapath strobes; everything visible reads 0 under reset
  always_comb begin
    do_swap      = 1'b0;
    wr_ok        = wr_en;
    swap_pending = 1'b0;
    clear_busy   = 1'b0;
`ifdef LED_FB_CLEAR_EN
    clr_en       = 1'b0;
`endif
    unique case (state)
      S_WAIT: begin
        do_swap      = (scan_row == FRAME_SYNC_ROW);
        swap_pending = 1'b1;
      end
`ifdef LED_FB_CLEAR_EN
      S_CLEAR: begin
        clr_en       = 1'b1;
        wr_ok        = 1'b0;
        clear_busy   = 1'b1;
        swap_pending = swap_lat;
      end
`endif
      default: begin
      end
    endcase
    if (reset) begin
      swap_pending = 1'b0;
      clear_busy   = 1'b0;
    end
    swap_done   = done_q & ~reset;
    red_array   = reset ? '0 : (sel ? red_b : red_a);
    green_array = reset ? '0 : (sel ? grn_b : grn_a);
  end

  // Frame storage: clear or write the back buffer, flip sel on swap
  always_ff @(posedge Clock) begin
    if (reset) begin
      red_a <= '0;
      grn_a <= '0;
      red_b <= '0;
      grn_b <= '0;
      sel   <= 1'b0;
    end else begin
`ifdef LED_FB_CLEAR_EN
      if (clr_en) begin
        if (sel) begin
          red_a[clr_cnt] <= 8'h00;
          grn_a[clr_cnt] <= 8'h00;
        end else begin
          red_b[clr_cnt] <= 8'h00;
          grn_b[clr_cnt] <= 8'h00;
        end
      end else
`endif
      if (wr_ok) begin
        if (sel) begin
          red_a[wr_row] <= wr_red;
          grn_a[wr_row] <= wr_green;
        end else begin
          red_b[wr_row] <= wr_red;
          grn_b[wr_row] <= wr_green;
        end
      end
      if (do_swap) begin
        sel <= ~sel;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: directed cases then random traffic.
// A frame-level model predicts per-cycle outputs and every swapped-in frame.
module tb_led_frame_buffer;

  logic            Clock = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [7:0]      wr_red;
  logic [7:0]      wr_green;
  logic            swap_req;
  logic            clear_req;
  logic [2:0]      scan_row;
  logic [7:0][7:0] red_array;
  logic [7:0][7:0] green_array;
  logic            swap_pending;
  logic            swap_done;
  logic            clear_busy;

  always #5 Clock = ~Clock;

  led_frame_buffer dut (
    .Clock       (Clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_red      (wr_red),
    .wr_green    (wr_green),
    .swap_req    (swap_req),
    .clear_req   (clear_req),
    .scan_row    (scan_row),
    .red_array   (red_array),
    .green_array (green_array),
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .clear_busy  (clear_busy)
  );

  typedef struct packed {
    logic [63:0] r;
    logic [63:0] g;
    logic        p;
    logic        b;
    logic        d;
  } st_t;

  st_t          stq[$];
  logic [127:0] evq[$];
  int nchk = 0;
  int nerr = 0;

`ifdef LED_FB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  // model: two frames, which is shown, and what the engine is doing
  logic [7:0] mr[2][8];
  logic [7:0] mg[2][8];
  int msel  = 0;
  int mmode = 0;
  int mleft = 0;
  int mlat  = 0;
  int mdone = 0;

  function automatic logic [63:0] frame(input bit green);
    logic [63:0] f;
    for (int i = 0; i < 8; i++)
      f[8*i +: 8] = green ? mg[msel][i] : mr[msel][i];
    return f;
  endfunction

  task automatic cyc(input logic r, input logic we,
                     input logic [2:0] row, input logic [7:0] rd,
                     input logic [7:0] gr, input logic sw,
                     input logic cl, input logic [2:0] sc);
    st_t e;
    int  b;
    int  nd;
    reset     = r;
    wr_en     = we;
    wr_row    = row;
    wr_red    = rd;
    wr_green  = gr;
    swap_req  = sw;
    clear_req = cl;
    scan_row  = sc;
    e.r = r ? 64'd0 : frame(1'b0);
    e.g = r ? 64'd0 : frame(1'b1);
    e.p = !r && (mmode == 2 || (mmode == 1 && mlat != 0));
    e.b = !r && (mmode == 1);
    e.d = !r && (mdone != 0);
    if (r && mdone != 0 && evq.size() > 0)
      void'(evq.pop_front());
    stq.push_back(e);
    @(posedge Clock);
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        mr[0][i] = 8'h00; mg[0][i] = 8'h00;
        mr[1][i] = 8'h00; mg[1][i] = 8'h00;
      end
      msel = 0; mmode = 0; mleft = 0; mlat = 0; mdone = 0;
    end else begin
      b  = 1 - msel;
      nd = 0;
      if (mmode == 1) begin
        mr[b][8 - mleft] = 8'h00;
        mg[b][8 - mleft] = 8'h00;
      end else if (we) begin
        mr[b][row] = rd;
        mg[b][row] = gr;
      end
      case (mmode)
        0: begin
          if (CLR && cl) begin
            mmode = 1; mleft = 8; mlat = int'(sw);
          end else if (sw) begin
            mmode = 2;
          end
        end
        1: begin
          if (sw) mlat = 1;
          mleft = mleft - 1;
          if (mleft == 0) begin
            mmode = (mlat != 0) ? 2 : 0;
            mlat  = 0;
          end
        end
        default: begin
          if (sc == 3'd7) begin
            msel  = b;
            mmode = 0;
            nd    = 1;
            evq.push_back({frame(1'b0), frame(1'b1)});
          end
        end
      endcase
      mdone = nd;
    end
    #1;
  endtask

  task automatic idle(input logic [2:0] sc);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, sc);
  endtask

  // monitor: per-cycle status and a frame check on every swap_done
  always @(negedge Clock) begin
    st_t e;
    logic [127:0] f;
    if (stq.size() > 0) begin
      e = stq.pop_front();
      nchk++;
      if ({red_array, green_array, swap_pending, clear_busy, swap_done} !== e) begin
        nerr++;
        $display("FAIL status t=%0t got r=%h g=%h p=%b b=%b d=%b want r=%h g=%h p=%b b=%b d=%b",
                 $time, red_array, green_array, swap_pending, clear_busy,
                 swap_done, e.r, e.g, e.p, e.b, e.d);
      end
    end
    if (swap_done === 1'b1) begin
      nchk++;
      if (evq.size() == 0) begin
        nerr++;
        $display("FAIL swap_event t=%0t got swap_done=1 want no swap", $time);
      end else begin
        f = evq.pop_front();
        if ({red_array, green_array} !== f) begin
          nerr++;
          $display("FAIL swap_frame t=%0t got %h want %h",
                   $time, {red_array, green_array}, f);
        end
      end
    end
  end

  logic [2:0] sc;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_row = 3'd0; wr_red = 8'h00;
    wr_green = 8'h00; swap_req = 1'b0; clear_req = 1'b0; scan_row = 3'd0;
    for (int i = 0; i < 8; i++) begin
      mr[0][i] = 8'h00; mg[0][i] = 8'h00;
      mr[1][i] = 8'h00; mg[1][i] = 8'h00;
    end
    @(posedge Clock);
    #1;
    cyc(1'b1, 1'b1, 3'd1, 8'h11, 8'h22, 1'b1, 1'b1, 3'd7);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    // row 3 write then swap at the sync row
    cyc(1'b0, 1'b1, 3'd3, 8'hA5, 8'h0F, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0);
    for (int s = 1; s < 8; s++) idle(3'(s));
    idle(3'd0);
    // back-buffer write must stay invisible
    cyc(1'b0, 1'b1, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 3'd7);
    for (int s = 0; s < 20; s++) idle(3'(s));
    // swap held off while scan sits at row 2
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2);
    for (int s = 0; s < 10; s++) idle(3'd2);
    idle(3'd7);
    idle(3'd0);
    idle(3'd0);
    // fill back with FF, then clear+swap together
    for (int s = 0; s < 8; s++)
      cyc(1'b0, 1'b1, 3'(s), 8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0);
    for (int s = 0; s < 8; s++) idle(3'd0);
    idle(3'd7);
    idle(3'd0);
    // reset lands three cycles into a clear with a latched swap
    cyc(1'b0, 1'b1, 3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0);
    idle(3'd0);
    idle(3'd0);
    idle(3'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd7);
    for (int s = 0; s < 12; s++) idle(3'd7);
    // write on the swap edge goes to the incoming front
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0);
    idle(3'd3);
    cyc(1'b0, 1'b1, 3'd5, 8'h3C, 8'hC3, 1'b0, 1'b0, 3'd7);
    idle(3'd0);
    idle(3'd1);
    // random traffic with a free-running scanner
    sc = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      sc = (n % 37 == 0) ? 3'($urandom_range(0, 7)) : sc + 3'd1;
      cyc(1'($urandom_range(0, 149) == 0),
          1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)),
          8'($urandom), 8'($urandom),
          1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 11) == 0),
          sc);
    end
    for (int s = 0; s < 14; s++) idle(3'd7);
    nchk++;
    if (evq.size() != 0) begin
      nerr++;
      $display("FAIL swap_missing got %0d unshown swaps want 0", evq.size());
    end
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer.md
LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

Interface
REQ-001 SHALL provide parameter: FRAME_SYNC_ROW, 3'd7, scan row at which a pending buffer swap executes.
REQ-002 SHALL provide port: Clock  input  1  system clock; all state updates on posedge.
REQ-003 SHALL provide port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: wr_en  input  1  write one row of back buffer this cycle.
REQ-005 SHALL provide port: wr_row  input  3  row index for write.
REQ-006 SHALL provide port: wr_red  input  8  red column bits for written row.
REQ-007 SHALL provide port: wr_green  input  8  green column bits for written row.
REQ-008 SHALL provide port: swap_req  input  1  single-cycle request to exchange front/back buffers.
REQ-009 SHALL provide port: clear_req  input  1  single-cycle request to zero back buffer.
REQ-010 SHALL provide port: scan_row  input  3  current row index of downstream matrix scanner.
REQ-011 SHALL provide port: red_array  output  [7:0][7:0]  front-buffer red frame, row-major, to scanner.
REQ-012 SHALL provide port: green_array  output  [7:0][7:0]  front-buffer green frame to scanner.
REQ-013 SHALL provide port: swap_pending  output  1  high while a swap is accepted but not executed.
REQ-014 SHALL provide port: swap_done  output  1  one-cycle pulse, asserted in cycle after swap edge.
REQ-015 SHALL provide port: clear_busy  output  1  high while clear engine runs.

Function
REQ-016 SHALL hold two 8x8 red+green buffers (A, B) and a select bit sel; front = A when sel=0, else B; back = other.
REQ-017 SHALL drive red_array/green_array combinationally from front buffer; a write to back never changes outputs.
REQ-018 SHALL implement FSM states IDLE, CLEAR, WAIT.
REQ-019 IDLE: clear_req -> CLEAR (row counter 0); else swap_req -> WAIT; simultaneous clear_req+swap_req -> CLEAR with swap latched.
REQ-020 CLEAR: zero back row[counter] each cycle, 8 cycles (rows 0..7); after row 7 -> WAIT if swap latched, else IDLE; clear_busy high all 8 cycles.
REQ-021 CLEAR: swap_req latches swap; clear_req ignored; wr_en ignored (clear has priority).
REQ-022 WAIT: swap_pending high; when scan_row == FRAME_SYNC_ROW toggle sel at that edge, -> IDLE, swap_done=1 next cycle only.
REQ-023 WAIT: swap_req and clear_req ignored; wr_en accepted.
REQ-024 Write in swap cycle SHALL land in outgoing back buffer (the one becoming front) and be visible after the swap.
REQ-025 wr_en in IDLE/WAIT SHALL write wr_red/wr_green to back[wr_row] at next edge, one-cycle latency.
REQ-026 swap_pending SHALL be high from cycle after acceptance until the swap edge, including latched swap during CLEAR.
REQ-027 Swap latency SHALL be 1 to 8 cycles after WAIT entry, never mid-frame relative to FRAME_SYNC_ROW.

Reset
REQ-028 reset SHALL zero both buffers, sel=0, FSM=IDLE, clear counter=0, swap latch=0.
REQ-029 Under reset red_array, green_array, swap_pending, swap_done, clear_busy SHALL be 0.
REQ-030 reset mid-CLEAR or mid-WAIT SHALL abort operation with no swap and no swap_done.
REQ-031 Input requests asserted in reset cycle SHALL be discarded.

Configuration
REQ-032 Macro LED_FB_CLEAR_EN SHALL compile in the CLEAR state and clear engine.
REQ-033 With LED_FB_CLEAR_EN: behaviour per REQ-019..021.
REQ-034 Without LED_FB_CLEAR_EN: clear_req ignored, clear_busy tied 0, CLEAR state absent, all else unchanged.

Verification
REQ-035 After reset, write row 3 red=8'hA5, green=8'h0F, swap_req, scan_row cycles 0..7 -> swap at scan_row=7 edge, red_array[3]=8'hA5, green_array[3]=8'h0F, swap_done one cycle.
REQ-036 Write back row 0 red=8'hFF without swap -> red_array[0] stays 8'h00 for 20 cycles.
REQ-037 swap_req with scan_row held at 2 -> swap_pending stays 1, no swap; set scan_row=7 -> sel toggles, swap_pending falls.
REQ-038 Back full of 8'hFF, clear_req+swap_req same cycle -> clear_busy high 8 cycles, then swap; front all 8'h00 (LED_FB_CLEAR_EN); without macro -> front all 8'hFF.
REQ-039 reset asserted 3 cycles into CLEAR with swap latched -> all outputs 0, no swap_done afterwards.
REQ-040 wr_en row 5 red=8'h3C in the swap edge cycle -> red_array[5]=8'h3C after swap.
